// File: rtl/mmcm_rst_sequencer.sv
// rtl/mmcm_rst_sequencer.sv - MMCM reset pulse, lock qualification and staggered domain reset release
//
// Purpose:
//    Supervises one MMCM from the free-running board clock. After rst_in it
//    pulses the MMCM reset, then waits for LOCKED. LOCKED must stay high for
//    LOCK_STABLE_CYCLES before the per-domain resets are released one by one,
//    lowest index first. If LOCKED does not appear in time, the MMCM is reset
//    again. After MAX_RETRIES timeouts (when non-zero) the block parks in FAIL.
//    If lock is lost after it was seen, every domain goes back into reset and
//    the block waits for lock again without resetting the MMCM.
//
// Ports:
//    clk_in     in   free-running reference clock (never an MMCM output)
//    rst_in     in   synchronous active-high reset
//    mmcm_lock  in   MMCM LOCKED, asynchronous to clk_in
//    mmcm_rst   out  MMCM RST
//    rst_out    out  [NUM_RST] active-high domain resets. Bit i is for clk_out(i)
//    all_ready  out  every domain reset released
//    retry_cnt  out  [8] lock timeouts since rst_in, saturating at 255
//    lock_fail  out  sticky, retries exhausted

module mmcm_rst_sequencer #(
   parameter int NUM_RST             = 7,
   parameter int LOCK_SYNC_STAGES    = 3,
   parameter int MMCM_RST_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int RST_STAGGER_CYCLES  = 8,
   parameter int MAX_RETRIES         = 0
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               mmcm_lock,
   output logic               mmcm_rst,
   output logic [NUM_RST-1:0] rst_out,
   output logic               all_ready,
   output logic [7:0]         retry_cnt,
   output logic               lock_fail
);

   localparam int RST_CW = $clog2(MMCM_RST_CYCLES) + 1;
   localparam int STB_CW = $clog2(LOCK_STABLE_CYCLES) + 1;
   localparam int TO_CW  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
   localparam int STG_CW = $clog2(RST_STAGGER_CYCLES) + 1;

   // Terminal values: each counter compares against the last count value
   // instead of counting past it, so none of them can wrap.
   localparam logic [RST_CW-1:0] RST_LAST = RST_CW'(MMCM_RST_CYCLES - 1);
   localparam logic [STB_CW-1:0] STB_LAST = STB_CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [STG_CW-1:0] STG_LAST = STG_CW'(RST_STAGGER_CYCLES - 1);

   localparam logic [7:0]         MAX_R    = 8'(MAX_RETRIES);
   localparam logic [NUM_RST-1:0] ALL_ONES = '1;

   typedef enum logic [2:0] {
      S_MMCM_RST  = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RELEASE   = 3'd3,
      S_RUN       = 3'd4,
      S_FAIL      = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [LOCK_SYNC_STAGES-1:0] sync_q, sync_d;
   logic [RST_CW-1:0]         rst_cnt_q, rst_cnt_d;
   logic [STB_CW-1:0]         stb_cnt_q, stb_cnt_d;
   logic [TO_CW-1:0]          to_cnt_q, to_cnt_d;
   logic [STG_CW-1:0]         stg_cnt_q, stg_cnt_d;
   logic                      mmcm_rst_q, mmcm_rst_d;
   logic [NUM_RST-1:0]        rst_out_q, rst_out_d;
   logic                      all_ready_q, all_ready_d;
   logic [7:0]                retry_cnt_q, retry_cnt_d;
   logic                      lock_fail_q, lock_fail_d;

   logic                      lock_s;
   logic [7:0]                retry_inc;

   // Only the last synchroniser flop is ever looked at.
   assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

   assign retry_inc = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[LOCK_SYNC_STAGES-2:0], mmcm_lock};
      rst_cnt_d   = rst_cnt_q;
      stb_cnt_d   = stb_cnt_q;
      to_cnt_d    = to_cnt_q;
      stg_cnt_d   = stg_cnt_q;
      mmcm_rst_d  = mmcm_rst_q;
      rst_out_d   = rst_out_q;
      all_ready_d = all_ready_q;
      retry_cnt_d = retry_cnt_q;
      lock_fail_d = lock_fail_q;

      case (state_q)
         S_MMCM_RST: begin
            mmcm_rst_d  = 1'b1;
            rst_out_d   = ALL_ONES;
            all_ready_d = 1'b0;
            if (rst_cnt_q == RST_LAST) begin
               mmcm_rst_d = 1'b0;
               rst_cnt_d  = '0;
               to_cnt_d   = '0;
               state_d    = S_WAIT_LOCK;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_CW'(1);
            end
         end

         S_WAIT_LOCK: begin
            if (lock_s) begin
               stb_cnt_d = '0;
               state_d   = S_STABLE;
            end else if (to_cnt_q == TO_LAST) begin
               // Lock timeout: count it, then either retry or give up.
               retry_cnt_d = retry_inc;
               to_cnt_d    = '0;
               mmcm_rst_d  = 1'b1;
               if ((MAX_RETRIES != 0) && (retry_inc == MAX_R)) begin
                  lock_fail_d = 1'b1;
                  state_d     = S_FAIL;
               end else begin
                  rst_cnt_d = '0;
                  state_d   = S_MMCM_RST;
               end
            end else begin
               to_cnt_d = to_cnt_q + TO_CW'(1);
            end
         end

         S_STABLE: begin
            if (!lock_s) begin
               // A single low sample discards the stability run so far.
               stb_cnt_d = '0;
               to_cnt_d  = '0;
               state_d   = S_WAIT_LOCK;
            end else if (stb_cnt_q == STB_LAST) begin
               // Bit 0 is released on the same edge RELEASE is entered.
               stb_cnt_d = '0;
               stg_cnt_d = '0;
               rst_out_d = ALL_ONES << 1;
               state_d   = S_RELEASE;
            end else begin
               stb_cnt_d = stb_cnt_q + STB_CW'(1);
            end
         end

         S_RELEASE: begin
            if (!lock_s) begin
               rst_out_d   = ALL_ONES;
               all_ready_d = 1'b0;
               stg_cnt_d   = '0;
               to_cnt_d    = '0;
               state_d     = S_WAIT_LOCK;
            end else if (rst_out_q == '0) begin
               all_ready_d = 1'b1;
               stg_cnt_d   = '0;
               state_d     = S_RUN;
            end else if (stg_cnt_q == STG_LAST) begin
               // Shifting in zeros from the bottom releases strictly in index order.
               stg_cnt_d = '0;
               rst_out_d = rst_out_q << 1;
            end else begin
               stg_cnt_d = stg_cnt_q + STG_CW'(1);
            end
         end

         S_RUN: begin
            if (!lock_s) begin
               rst_out_d   = ALL_ONES;
               all_ready_d = 1'b0;
               to_cnt_d    = '0;
               state_d     = S_WAIT_LOCK;
            end
         end

         S_FAIL: begin
            // Terminal until rst_in: lock is deliberately ignored here.
            mmcm_rst_d  = 1'b1;
            rst_out_d   = ALL_ONES;
            all_ready_d = 1'b0;
            lock_fail_d = 1'b1;
         end

         default: begin
            mmcm_rst_d  = 1'b1;
            rst_out_d   = ALL_ONES;
            all_ready_d = 1'b0;
            rst_cnt_d   = '0;
            state_d     = S_MMCM_RST;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= S_MMCM_RST;
         sync_q      <= '0;
         rst_cnt_q   <= '0;
         stb_cnt_q   <= '0;
         to_cnt_q    <= '0;
         stg_cnt_q   <= '0;
         mmcm_rst_q  <= 1'b1;
         rst_out_q   <= ALL_ONES;
         all_ready_q <= 1'b0;
         retry_cnt_q <= 8'd0;
         lock_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         rst_cnt_q   <= rst_cnt_d;
         stb_cnt_q   <= stb_cnt_d;
         to_cnt_q    <= to_cnt_d;
         stg_cnt_q   <= stg_cnt_d;
         mmcm_rst_q  <= mmcm_rst_d;
         rst_out_q   <= rst_out_d;
         all_ready_q <= all_ready_d;
         retry_cnt_q <= retry_cnt_d;
         lock_fail_q <= lock_fail_d;
      end
   end

   assign mmcm_rst  = mmcm_rst_q;
   assign rst_out   = rst_out_q;
   assign all_ready = all_ready_q;
   assign retry_cnt = retry_cnt_q;
   assign lock_fail = lock_fail_q;

endmodule
